// File: rtl/blit_arb_pkg.sv
// Shared owner codes, state encoding and priority helpers for the main-bus arbiter.
package blit_arb_pkg;

    localparam int unsigned OWNER_W   = 3;
    localparam int unsigned NUM_CODES = 8;
    localparam int unsigned ACK_W     = 6;
    localparam int unsigned STATE_W   = 2;
    localparam int unsigned PCNT_W    = 5;
    localparam int unsigned STAT_W    = PCNT_W + OWNER_W;

    typedef logic [OWNER_W-1:0] owner_t;

    localparam owner_t OWNER_NONE  = 3'd0;
    localparam owner_t OWNER_REF   = 3'd1;
    localparam owner_t OWNER_OP    = 3'd2;
    localparam owner_t OWNER_BLITH = 3'd3;
    localparam owner_t OWNER_GPU   = 3'd4;
    localparam owner_t OWNER_DSP   = 3'd5;
    localparam owner_t OWNER_BLITL = 3'd6;
    localparam owner_t OWNER_CPU   = 3'd7;

    localparam logic [STATE_W-1:0] ST_IDLE    = 2'd0;
    localparam logic [STATE_W-1:0] ST_OWN     = 2'd1;
    localparam logic [STATE_W-1:0] ST_HANDOFF = 2'd2;

    // Ack bit positions
    localparam int unsigned ACK_REF  = 0;
    localparam int unsigned ACK_OP   = 1;
    localparam int unsigned ACK_BLIT = 2;
    localparam int unsigned ACK_GPU  = 3;
    localparam int unsigned ACK_DSP  = 4;
    localparam int unsigned ACK_CPU  = 5;

    // Lower rank wins; GPU and DSP share a level.
    function automatic logic [2:0] class_rank(input owner_t code);
        logic [2:0] r;
        case (code)
            OWNER_REF:             r = 3'd0;
            OWNER_OP:              r = 3'd1;
            OWNER_BLITH:           r = 3'd2;
            OWNER_GPU, OWNER_DSP:  r = 3'd3;
            OWNER_BLITL:           r = 3'd4;
            OWNER_CPU:             r = 3'd5;
            default:               r = 3'd7;
        endcase
        return r;
    endfunction

    function automatic logic is_blit(input owner_t code);
        return (code == OWNER_BLITH) || (code == OWNER_BLITL);
    endfunction

    function automatic logic [ACK_W-1:0] ack_decode(input owner_t code);
        logic [ACK_W-1:0] a;
        a = '0;
        case (code)
            OWNER_REF:                a[ACK_REF]  = 1'b1;
            OWNER_OP:                 a[ACK_OP]   = 1'b1;
            OWNER_BLITH, OWNER_BLITL: a[ACK_BLIT] = 1'b1;
            OWNER_GPU:                a[ACK_GPU]  = 1'b1;
            OWNER_DSP:                a[ACK_DSP]  = 1'b1;
            OWNER_CPU:                a[ACK_CPU]  = 1'b1;
            default:                  a = '0;
        endcase
        return a;
    endfunction

endpackage

// File: rtl/arb_prio_sel.sv
// Combinational winner select: lowest class rank wins, GPU/DSP tie broken round-robin.
module arb_prio_sel
    import blit_arb_pkg::*;
(
    input  logic [NUM_CODES-1:0] req,
    input  logic                 rr_last_dsp,
    input  owner_t               excl,
    output owner_t               winner_c,
    output logic                 any_c
);

    logic [NUM_CODES-1:0] masked;
    logic [2:0]           best_rank;

    always_comb begin
        masked    = req;
        masked[0] = 1'b0;
        // Excluding the blitter removes it as a device, whatever class it last held.
        if (is_blit(excl)) begin
            masked[OWNER_BLITH] = 1'b0;
            masked[OWNER_BLITL] = 1'b0;
        end else begin
            masked[excl] = 1'b0;
        end

        winner_c  = OWNER_NONE;
        best_rank = 3'd7;
        for (int unsigned c = 1; c < NUM_CODES; c++) begin
            if (masked[3'(c)] && (class_rank(3'(c)) < best_rank)) begin
                winner_c  = 3'(c);
                best_rank = class_rank(3'(c));
            end
        end

        if ((winner_c == OWNER_GPU) && masked[OWNER_DSP] && !rr_last_dsp) begin
            winner_c = OWNER_DSP;
        end

        any_c = |masked;
    end

endmodule

// File: rtl/blit_bus_arb.sv
// Main-bus arbiter: one owner at a time, switches only on cycle_done, one dead HANDOFF cycle.
// Optional ARB_STAT_EN adds a preemption counter readable through statrd/stat_out/stat_oe.
module blit_bus_arb
    import blit_arb_pkg::*;
#(
    parameter int unsigned HOLD_MAX = 16,
    parameter int unsigned HCW      = 5
)
(
    input  logic               clk,
    input  logic               reset_n,
    input  logic               refreq,
    input  logic               opreq,
    input  logic               blit_breq_1,
    input  logic               blit_breq_0,
    input  logic               gpureq,
    input  logic               dspreq,
    input  logic               cpureq,
    input  logic               cycle_done,
`ifdef ARB_STAT_EN
    input  logic               statrd,
    output logic [STAT_W-1:0]  stat_out,
    output logic               stat_oe,
`endif
    output logic               ref_ack,
    output logic               op_ack,
    output logic               blit_ack,
    output logic               gpu_ack,
    output logic               dsp_ack,
    output logic               cpu_ack,
    output logic               bus_idle,
    output owner_t             owner
);

    logic [STATE_W-1:0]   state_q, state_d;
    owner_t               owner_q, owner_d;
    owner_t               prev_q, prev_d;
    logic [HCW-1:0]       hold_q, hold_d, hold_inc_c;
    logic                 rr_q, rr_d;
    logic [ACK_W-1:0]     ack_q;
    logic                 bus_idle_q;

    logic [NUM_CODES-1:0] req_c;
    logic [NUM_CODES-1:0] own_mask_c;
    owner_t               live_c;
    owner_t               excl_c;
    owner_t               win_c;
    logic                 any_c;
    logic                 owner_req_c;
    logic                 higher_c;
    logic                 other_c;
    logic                 expired_c;
    logic                 preempt_c;

    // Request vector indexed by owner code; the blitter appears in exactly one class.
    always_comb begin
        req_c              = '0;
        req_c[OWNER_REF]   = refreq;
        req_c[OWNER_OP]    = opreq;
        req_c[OWNER_BLITH] = blit_breq_1;
        req_c[OWNER_GPU]   = gpureq;
        req_c[OWNER_DSP]   = dspreq;
        req_c[OWNER_BLITL] = blit_breq_0 & ~blit_breq_1;
        req_c[OWNER_CPU]   = cpureq;
    end

    // Current owner's request and live class (blitter class tracks its request lines).
    always_comb begin
        owner_req_c = 1'b0;
        live_c      = owner_q;
        own_mask_c  = '0;
        case (owner_q)
            OWNER_REF:                owner_req_c = refreq;
            OWNER_OP:                 owner_req_c = opreq;
            OWNER_BLITH, OWNER_BLITL: owner_req_c = blit_breq_1 | blit_breq_0;
            OWNER_GPU:                owner_req_c = gpureq;
            OWNER_DSP:                owner_req_c = dspreq;
            OWNER_CPU:                owner_req_c = cpureq;
            default:                  owner_req_c = 1'b0;
        endcase
        if (is_blit(owner_q)) begin
            if (blit_breq_1) begin
                live_c = OWNER_BLITH;
            end else if (blit_breq_0) begin
                live_c = OWNER_BLITL;
            end
            own_mask_c[OWNER_BLITH] = 1'b1;
            own_mask_c[OWNER_BLITL] = 1'b1;
        end else begin
            own_mask_c[owner_q] = 1'b1;
        end
    end

    // Preempt: BLITL/CPU yield at once to higher classes; any owner but REF yields to any
    // contender once its hold budget (counting the current cycle_done) is spent.
    always_comb begin
        higher_c = 1'b0;
        for (int unsigned c = 1; c < NUM_CODES; c++) begin
            if (req_c[3'(c)] && (class_rank(3'(c)) < class_rank(live_c))) begin
                higher_c = 1'b1;
            end
        end
        other_c    = |(req_c & ~own_mask_c);
        hold_inc_c = (hold_q >= HCW'(HOLD_MAX)) ? hold_q : hold_q + HCW'(1);
        expired_c  = (hold_inc_c >= HCW'(HOLD_MAX));
        preempt_c  = (live_c != OWNER_REF) &&
                     ((higher_c && ((live_c == OWNER_BLITL) || (live_c == OWNER_CPU))) ||
                      (other_c && expired_c));
    end

    assign excl_c = (state_q == ST_HANDOFF) ? prev_q : OWNER_NONE;

    arb_prio_sel u_prio_sel (
        .req         (req_c),
        .rr_last_dsp (rr_q),
        .excl        (excl_c),
        .winner_c    (win_c),
        .any_c       (any_c)
    );

    // Next-state logic
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        prev_d  = prev_q;
        hold_d  = hold_q;
        rr_d    = rr_q;
        case (state_q)
            ST_IDLE, ST_HANDOFF: begin
                if (any_c) begin
                    state_d = ST_OWN;
                    owner_d = win_c;
                    hold_d  = '0;
                    if (win_c == OWNER_GPU) begin
                        rr_d = 1'b0;
                    end else if (win_c == OWNER_DSP) begin
                        rr_d = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                    owner_d = OWNER_NONE;
                end
            end
            ST_OWN: begin
                owner_d = live_c;
                if (cycle_done) begin
                    if (!owner_req_c) begin
                        prev_d  = owner_q;
                        owner_d = OWNER_NONE;
                        state_d = other_c ? ST_HANDOFF : ST_IDLE;
                    end else if (preempt_c) begin
                        prev_d  = owner_q;
                        owner_d = OWNER_NONE;
                        state_d = ST_HANDOFF;
                    end else begin
                        hold_d = hold_inc_c;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                owner_d = OWNER_NONE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            owner_q    <= OWNER_NONE;
            prev_q     <= OWNER_NONE;
            hold_q     <= '0;
            rr_q       <= 1'b1;
            ack_q      <= '0;
            bus_idle_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            prev_q     <= prev_d;
            hold_q     <= hold_d;
            rr_q       <= rr_d;
            ack_q      <= ack_decode(owner_d);
            bus_idle_q <= (state_d == ST_IDLE);
        end
    end

    assign ref_ack  = ack_q[ACK_REF];
    assign op_ack   = ack_q[ACK_OP];
    assign blit_ack = ack_q[ACK_BLIT];
    assign gpu_ack  = ack_q[ACK_GPU];
    assign dsp_ack  = ack_q[ACK_DSP];
    assign cpu_ack  = ack_q[ACK_CPU];
    assign bus_idle = bus_idle_q;
    assign owner    = owner_q;

`ifdef ARB_STAT_EN
    logic [PCNT_W-1:0] pcnt_q;
    logic              preempt_evt_c;

    assign preempt_evt_c = (state_q == ST_OWN) && cycle_done && owner_req_c && preempt_c;

    // Preemption counter, saturating, cleared after each read cycle
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pcnt_q <= '0;
        end else if (statrd) begin
            pcnt_q <= '0;
        end else if (preempt_evt_c && (pcnt_q != '1)) begin
            pcnt_q <= pcnt_q + PCNT_W'(1);
        end
    end

    assign stat_out = {pcnt_q, owner_q};
    assign stat_oe  = statrd;
`endif

endmodule

// File: tb/tb_blit_bus_arb.sv
// Scoreboard bench for blit_bus_arb: stimulus queues expected outputs per cycle, a negedge monitor checks them.
module tb_blit_bus_arb;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       refreq, opreq, blit_breq_1, blit_breq_0, gpureq, dspreq, cpureq, cycle_done;
    logic       ref_ack, op_ack, blit_ack, gpu_ack, dsp_ack, cpu_ack, bus_idle;
    logic [2:0] owner;
`ifdef ARB_STAT_EN
    logic       statrd;
    logic [7:0] stat_out;
    logic       stat_oe;
`endif

    localparam logic [5:0] A_NONE = 6'b000000;
    localparam logic [5:0] A_OP   = 6'b000010;
    localparam logic [5:0] A_BLIT = 6'b000100;
    localparam logic [5:0] A_GPU  = 6'b001000;
    localparam logic [5:0] A_DSP  = 6'b010000;

    typedef struct {
        int         cyc;
        logic [5:0] ack;
        logic       idle;
        logic [2:0] own;
        logic       chk_stat;
        logic [7:0] stat;
        logic       oe;
        string      name;
    } exp_t;

    exp_t exp_q[$];
    int   cyc      = 0;
    int   chk_cnt  = 0;
    int   pass_cnt = 0;

    blit_bus_arb #(.HOLD_MAX(16), .HCW(5)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .refreq      (refreq),
        .opreq       (opreq),
        .blit_breq_1 (blit_breq_1),
        .blit_breq_0 (blit_breq_0),
        .gpureq      (gpureq),
        .dspreq      (dspreq),
        .cpureq      (cpureq),
        .cycle_done  (cycle_done),
`ifdef ARB_STAT_EN
        .statrd      (statrd),
        .stat_out    (stat_out),
        .stat_oe     (stat_oe),
`endif
        .ref_ack     (ref_ack),
        .op_ack      (op_ack),
        .blit_ack    (blit_ack),
        .gpu_ack     (gpu_ack),
        .dsp_ack     (dsp_ack),
        .cpu_ack     (cpu_ack),
        .bus_idle    (bus_idle),
        .owner       (owner)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int dc, input logic [5:0] a, input logic idle, input logic [2:0] own,
                            input logic cs, input logic [7:0] st, input logic oe, input string nm);
        exp_t e;
        e.cyc = cyc + dc; e.ack = a; e.idle = idle; e.own = own;
        e.chk_stat = cs; e.stat = st; e.oe = oe; e.name = nm;
        exp_q.push_back(e);
    endtask

    task automatic exp_out(input int dc, input logic [5:0] a, input logic idle, input logic [2:0] own,
                           input string nm);
        push_exp(dc, a, idle, own, 1'b0, 8'h00, 1'b0, nm);
    endtask

    task automatic clear_inputs();
        refreq = 0; opreq = 0; blit_breq_1 = 0; blit_breq_0 = 0;
        gpureq = 0; dspreq = 0; cpureq = 0; cycle_done = 0;
`ifdef ARB_STAT_EN
        statrd = 0;
`endif
    endtask

    task automatic do_reset(input string nm);
        clear_inputs();
        reset_n = 0;
        tick();
        reset_n = 1;
        exp_out(0, A_NONE, 1'b1, 3'd0, nm);
    endtask

    // Monitor: compares every queued expectation in its target cycle
    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            exp_t       e;
            logic [5:0] got_ack;
            logic       ok;
            e       = exp_q.pop_front();
            got_ack = {cpu_ack, dsp_ack, gpu_ack, blit_ack, op_ack, ref_ack};
            ok      = (e.cyc == cyc) && (got_ack === e.ack) && (bus_idle === e.idle) && (owner === e.own);
`ifdef ARB_STAT_EN
            if (e.chk_stat && ((stat_out !== e.stat) || (stat_oe !== e.oe))) ok = 1'b0;
            if (e.chk_stat && !ok)
                $display("FAIL %s cyc=%0d got stat_out=%h stat_oe=%b exp stat_out=%h stat_oe=%b",
                         e.name, cyc, stat_out, stat_oe, e.stat, e.oe);
`endif
            chk_cnt++;
            if (ok) begin
                pass_cnt++;
            end else begin
                $display("FAIL %s cyc=%0d(exp cyc %0d) got ack=%b idle=%b owner=%0d exp ack=%b idle=%b owner=%0d",
                         e.name, cyc, e.cyc, got_ack, bus_idle, owner, e.ack, e.idle, e.own);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d pending=%0d", cyc, exp_q.size());
        $fatal(1, "watchdog expired");
    end

    initial begin
        clear_inputs();
        reset_n = 0;

        // Test 1: single GPU grant, ack held until cycle_done after request drops
        do_reset("reset_state");
        gpureq = 1;
        exp_out(1, A_GPU, 1'b0, 3'd4, "t1_grant");
        tick();
        gpureq = 0;
        exp_out(1, A_GPU, 1'b0, 3'd4, "t1_hold_no_done");
        tick();
        cycle_done = 1;
        exp_out(1, A_NONE, 1'b1, 3'd0, "t1_release_idle");
        tick();
        cycle_done = 0;

        // Test 2: GPU/DSP alternate after 16 cycle_done pulses each, one dead cycle per change
        do_reset("t2_reset");
        gpureq = 1; dspreq = 1;
        exp_out(1,  A_GPU,  1'b0, 3'd4, "t2_first_gpu");
        exp_out(32, A_GPU,  1'b0, 3'd4, "t2_gpu_hold15");
        exp_out(33, A_NONE, 1'b0, 3'd0, "t2_handoff1");
        exp_out(34, A_DSP,  1'b0, 3'd5, "t2_dsp");
        exp_out(64, A_DSP,  1'b0, 3'd5, "t2_dsp_hold15");
        exp_out(65, A_NONE, 1'b0, 3'd0, "t2_handoff2");
        exp_out(66, A_GPU,  1'b0, 3'd4, "t2_gpu_again");
        for (int i = 0; i <= 66; i++) begin
            cycle_done = (i > 0) && (i % 2 == 0);
            tick();
        end
        gpureq = 0; dspreq = 0; cycle_done = 1;
        exp_out(1, A_NONE, 1'b1, 3'd0, "t2_idle");
        tick();
        cycle_done = 0;

        // Test 3: low-priority blitter preempted by OP at the next cycle_done
        do_reset("t3_reset");
        blit_breq_0 = 1; cpureq = 1;
        exp_out(1, A_BLIT, 1'b0, 3'd6, "t3_blitl_grant");
        tick();
        opreq = 1;
        exp_out(1, A_BLIT, 1'b0, 3'd6, "t3_no_done_keep");
        tick();
        cycle_done = 1;
        exp_out(1, A_NONE, 1'b0, 3'd0, "t3_handoff");
        tick();
        cycle_done = 0;
        exp_out(1, A_OP, 1'b0, 3'd2, "t3_op_grant");
        tick();

        // Test 4: class upgrade to BLITH, GPU waits out the 16-pulse hold
        do_reset("t4_reset");
        blit_breq_0 = 1;
        exp_out(1, A_BLIT, 1'b0, 3'd6, "t4_blitl_grant");
        tick();
        blit_breq_1 = 1; gpureq = 1;
        exp_out(1, A_BLIT, 1'b0, 3'd3, "t4_class_blith");
        tick();
        for (int k = 1; k <= 16; k++) begin
            cycle_done = 1;
            if (k == 15) exp_out(1, A_BLIT, 1'b0, 3'd3, "t4_hold15");
            if (k == 16) exp_out(1, A_NONE, 1'b0, 3'd0, "t4_handoff");
            tick();
        end
        cycle_done = 0;
        exp_out(1, A_GPU, 1'b0, 3'd4, "t4_gpu_grant");
        tick();

        // Test 5: reset while DSP owns, simultaneous with cycle_done
        blit_breq_0 = 0; blit_breq_1 = 0; gpureq = 0; dspreq = 1; cycle_done = 1;
        exp_out(1, A_NONE, 1'b0, 3'd0, "t5_handoff");
        tick();
        cycle_done = 0;
        exp_out(1, A_DSP, 1'b0, 3'd5, "t5_dsp_grant");
        tick();
        reset_n = 0; cycle_done = 1; gpureq = 1; dspreq = 1;
        exp_out(1, A_NONE, 1'b1, 3'd0, "t5_reset_drop");
        tick();
        reset_n = 1; cycle_done = 0;
        exp_out(1, A_GPU, 1'b0, 3'd4, "t5_tie_gpu");
        tick();

`ifdef ARB_STAT_EN
        // Test 6: three preemptions counted, read clears
        do_reset("t6_reset");
        blit_breq_0 = 1;
        tick();
        for (int p = 0; p < 3; p++) begin
            opreq = 1; cycle_done = 1;
            tick();
            cycle_done = 0;
            tick();
            opreq = 0; cycle_done = 1;
            if (p == 2) blit_breq_0 = 0;
            tick();
            cycle_done = 0;
            tick();
        end
        statrd = 1;
        push_exp(0, A_NONE, 1'b1, 3'd0, 1'b1, 8'h18, 1'b1, "t6_read3");
        tick();
        push_exp(0, A_NONE, 1'b1, 3'd0, 1'b1, 8'h00, 1'b1, "t6_read0");
        tick();
        statrd = 0;
        push_exp(0, A_NONE, 1'b1, 3'd0, 1'b1, 8'h00, 1'b0, "t6_oe_low");
        tick();
`endif

        tick();
        tick();
        while (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk_cnt++;
            $display("FAIL %s never checked (exp cyc %0d, now %0d)", e.name, e.cyc, cyc);
        end
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
